// File: rtl/ofdm_symbol_framer_pkg.sv
// Shared types and sizing helpers for the OFDM symbol framer.
package symbol_framer_pkg;

  typedef enum logic [1:0] {IDLE, SKIP, CP, DATA} state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width covering 0..max-1; never narrower than one bit.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int sym_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofdm_symbol_framer_if.sv
// Sample stream in from the Minn buffer, framed symbol windows out to the FFT.
interface ofdm_symbol_framer_if #(
  parameter int W_IN  = 12,
  parameter int SYM_W = 4
);
  logic                   in_valid;
  logic signed [W_IN-1:0] in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q;
  logic                   in_frame_start;

  logic                   out_valid;
  logic signed [W_IN-1:0] out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q;
  logic                   out_sop;
  logic                   out_eop;
  logic [SYM_W-1:0]       out_sym_idx;
  logic                   out_is_cp;
  logic                   busy;
  logic                   frame_done;
  logic                   overrun;

  modport master (
    output in_valid, in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q, in_frame_start,
    input  out_valid, out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q,
           out_sop, out_eop, out_sym_idx, out_is_cp, busy, frame_done, overrun
  );

  modport slave (
    input  in_valid, in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q, in_frame_start,
    output out_valid, out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q,
           out_sop, out_eop, out_sym_idx, out_is_cp, busy, frame_done, overrun
  );
endinterface

// File: rtl/ofdm_symbol_framer.sv
// Skips the preamble after frame_start, strips CP, emits N_SYMBOLS FFT windows.
// SYMBOL_FRAMER_KEEP_CP_EN: also forward CP samples (flagged) with sop on the first CP sample.
module ofdm_symbol_framer
  import symbol_framer_pkg::*;
#(
  parameter int W_IN      = 12,
  parameter int N_FFT     = 1024,
  parameter int CP_LEN    = 128,
  parameter int N_SYMBOLS = 16,
  parameter int SKIP_LEN  = 2048
) (
  input logic                 clk,
  input logic                 rst_n,
  ofdm_symbol_framer_if.slave bus
);

  localparam int NUM_LANES = 4;
  localparam int CW = cnt_w(SKIP_LEN, CP_LEN, N_FFT);
  localparam int SW = sym_w(N_SYMBOLS);
  localparam logic [CW-1:0] SKIP_LAST = CW'(SKIP_LEN - 1);
  localparam logic [CW-1:0] CP_LAST   = CW'(CP_LEN - 1);
  localparam logic [CW-1:0] FFT_LAST  = CW'(N_FFT - 1);
  localparam logic [SW-1:0] SYM_LAST  = SW'(N_SYMBOLS - 1);

`ifdef SYMBOL_FRAMER_KEEP_CP_EN
  localparam bit KEEP_CP = 1'b1;
`else
  localparam bit KEEP_CP = 1'b0;
`endif

  state_t                            state, nxt;
  logic [CW-1:0]                     samp_cnt, samp_n;
  logic [SW-1:0]                     sym_cnt, sym_n;
  logic                              emit, sop, eop, is_cp, done, ovr;

  logic [NUM_LANES-1:0][W_IN-1:0]    in_lanes, lanes_q;
  logic [SW-1:0]                     sym_q;
  logic                              valid_q, sop_q, eop_q, is_cp_q, done_q, ovr_q;

  assign in_lanes = {bus.in_ch1_q, bus.in_ch1_i, bus.in_ch0_q, bus.in_ch0_i};

  always_comb begin
    nxt    = state;
    samp_n = samp_cnt;
    sym_n  = sym_cnt;
    emit   = 1'b0;
    sop    = 1'b0;
    eop    = 1'b0;
    is_cp  = 1'b0;
    done   = 1'b0;
    ovr    = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_frame_start) begin
        // Any frame_start restarts; outside IDLE the current frame is truncated.
        ovr   = (state != IDLE);
        sym_n = '0;
        if (SKIP_LEN == 1) begin
          nxt    = CP;
          samp_n = '0;
        end else begin
          nxt    = SKIP;
          samp_n = CW'(1);
        end
      end else begin
        case (state)
          SKIP: begin
            if (samp_cnt == SKIP_LAST) begin
              nxt    = CP;
              samp_n = '0;
              sym_n  = '0;
            end else begin
              samp_n = samp_cnt + 1'b1;
            end
          end
          CP: begin
            emit  = KEEP_CP;
            is_cp = KEEP_CP;
            sop   = KEEP_CP && (samp_cnt == '0);
            if (samp_cnt == CP_LAST) begin
              nxt    = DATA;
              samp_n = '0;
            end else begin
              samp_n = samp_cnt + 1'b1;
            end
          end
          DATA: begin
            emit = 1'b1;
            sop  = !KEEP_CP && (samp_cnt == '0);
            if (samp_cnt == FFT_LAST) begin
              eop    = 1'b1;
              samp_n = '0;
              if (sym_cnt == SYM_LAST) begin
                done = 1'b1;
                nxt  = IDLE;
              end else begin
                sym_n = sym_cnt + 1'b1;
                nxt   = CP;
              end
            end else begin
              samp_n = samp_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      samp_cnt <= '0;
      sym_cnt  <= '0;
      lanes_q  <= '0;
      sym_q    <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      is_cp_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= nxt;
      samp_cnt <= samp_n;
      sym_cnt  <= sym_n;
      valid_q  <= emit;
      sop_q    <= sop;
      eop_q    <= eop;
      is_cp_q  <= is_cp;
      done_q   <= done;
      ovr_q    <= ovr;
      // Data and index hold through gaps so the FFT side sees stable values.
      if (emit) begin
        lanes_q <= in_lanes;
        sym_q   <= sym_cnt;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_ch0_i   = lanes_q[0];
  assign bus.out_ch0_q   = lanes_q[1];
  assign bus.out_ch1_i   = lanes_q[2];
  assign bus.out_ch1_q   = lanes_q[3];
  assign bus.out_sop     = sop_q;
  assign bus.out_eop     = eop_q;
  assign bus.out_sym_idx = sym_q;
  assign bus.out_is_cp   = is_cp_q;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_done  = done_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Directed bench for ofdm_symbol_framer: ramp data, ch0_i carries the sample index.
module tb_ofdm_symbol_framer;

  localparam int W_IN = 12, N_FFT = 8, CP_LEN = 2, N_SYM = 3, SKIP_LEN = 4;
`ifdef SYMBOL_FRAMER_KEEP_CP_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  typedef struct {
    int idx;
    bit sop;
    bit eop;
    bit cp;
    int sym;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofdm_symbol_framer_if #(.W_IN(W_IN), .SYM_W(2)) bus ();

  ofdm_symbol_framer #(
    .W_IN(W_IN), .N_FFT(N_FFT), .CP_LEN(CP_LEN), .N_SYMBOLS(N_SYM), .SKIP_LEN(SKIP_LEN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  rec_t got_q[$], exp_q[$];
  int   done_q[$];
  int   tests = 0, fails = 0;
  int   ovr_cnt = 0, gap_viol = 0, lane_err = 0;
  bit   busy_at_done = 1'b1;
  logic prev_in_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  always @(posedge clk) prev_in_valid <= bus.in_valid;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        rec_t r;
        r.idx = int'($signed(bus.out_ch0_i));
        r.sop = bus.out_sop;
        r.eop = bus.out_eop;
        r.cp  = bus.out_is_cp;
        r.sym = int'(bus.out_sym_idx);
        got_q.push_back(r);
        if (int'($signed(bus.out_ch0_q)) != r.idx + 100 ||
            int'($signed(bus.out_ch1_i)) != r.idx + 200 ||
            int'($signed(bus.out_ch1_q)) != -r.idx) lane_err++;
      end
      if (bus.frame_done) begin
        done_q.push_back(int'($signed(bus.out_ch0_i)));
        busy_at_done = bus.busy;
      end
      if (bus.overrun) ovr_cnt++;
      if (!prev_in_valid && bus.out_valid) gap_viol++;
    end
  end

  task automatic drive(input int idx, input bit v, input bit fs);
    @(posedge clk);
    #1;
    bus.in_valid       = v;
    bus.in_frame_start = fs;
    bus.in_ch0_i       = W_IN'(idx);
    bus.in_ch0_q       = W_IN'(idx + 100);
    bus.in_ch1_i       = W_IN'(idx + 200);
    bus.in_ch1_q       = W_IN'(-idx);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1500, 1'b0, 1'b0);
  endtask

  // Ramp first..last; optional idle cycle after every two valid samples.
  task automatic run(input int first, input int last, input int fs_a, input int fs_b, input bit gaps);
    int n;
    n = 0;
    for (int i = first; i <= last; i++) begin
      drive(i, 1'b1, (i == fs_a) || (i == fs_b));
      n++;
      if (gaps && (n % 2 == 0)) drive(1500, 1'b0, 1'b0);
    end
  endtask

  // Expected windows of a frame started at fs_idx, keeping only indices below stop.
  task automatic exp_frame(input int fs_idx, input int stop);
    int base;
    rec_t r;
    for (int s = 0; s < N_SYM; s++) begin
      base = fs_idx + SKIP_LEN + s * (CP_LEN + N_FFT);
      if (KEEP) begin
        for (int k = 0; k < CP_LEN; k++) begin
          r = '{base + k, k == 0, 1'b0, 1'b1, s};
          if (r.idx < stop) exp_q.push_back(r);
        end
      end
      for (int k = 0; k < N_FFT; k++) begin
        r = '{base + CP_LEN + k, !KEEP && k == 0, k == N_FFT - 1, 1'b0, s};
        if (r.idx < stop) exp_q.push_back(r);
      end
    end
  endtask

  function automatic logic [31:0] pk(input rec_t r);
    logic [15:0] i16;
    logic [1:0]  s2;
    i16 = r.idx[15:0];
    s2  = r.sym[1:0];
    return {8'd0, i16, 3'd0, r.sop, r.eop, r.cp, s2};
  endfunction

  task automatic cmp(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), pk(got_q[i]), pk(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic int first_done();
    return (done_q.size() > 0) ? done_q[0] : -1;
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_frame_start = 1'b0;
    bus.in_ch0_i = '0; bus.in_ch0_q = '0; bus.in_ch1_i = '0; bus.in_ch1_q = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.out_ch0_i, 0);
    chk("rst_flags", {bus.out_sop, bus.out_eop, bus.frame_done, bus.overrun, bus.out_is_cp}, 0);
    rst_n = 1'b1;

    // 1: continuous stream, frame_start at 10
    run(0, 30, 10, -1, 1'b0);
    chk("c1_busy_mid", bus.busy, 1);
    run(31, 50, -1, -1, 1'b0);
    idle(2);
    exp_frame(10, 1000);
    cmp("c1");
    chk("c1_ndone", done_q.size(), 1);
    chk("c1_done_idx", first_done(), 43);
    chk("c1_busy_at_done", busy_at_done, 0);
    chk("c1_busy_end", bus.busy, 0);
    chk("c1_ovr", ovr_cnt, 0);
    done_q.delete();

    // 2: same with a gap every third cycle
    gap_viol = 0;
    run(0, 50, 10, -1, 1'b1);
    idle(2);
    exp_frame(10, 1000);
    cmp("c2");
    chk("c2_done_idx", first_done(), 43);
    chk("c2_gap_viol", gap_viol, 0);
    done_q.delete();

    // 3: restart at 20 mid-symbol 0
    ovr_cnt = 0;
    run(0, 60, 10, 20, 1'b0);
    idle(2);
    exp_frame(10, 20);
    exp_frame(20, 1000);
    cmp("c3");
    chk("c3_ovr", ovr_cnt, 1);
    chk("c3_done_idx", first_done(), 53);
    done_q.delete();

    // 4: async reset mid-DATA
    run(0, 18, 10, -1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("c4_rst_valid", bus.out_valid, 0);
    chk("c4_rst_data", bus.out_ch0_i, 0);
    chk("c4_rst_busy", bus.busy, 0);
    exp_frame(10, 18);
    cmp("c4a");
    @(negedge clk);
    rst_n = 1'b1;
    run(19, 30, -1, -1, 1'b0);
    idle(2);
    chk("c4_quiet", got_q.size(), 0);
    chk("c4_quiet_busy", bus.busy, 0);
    chk("c4_ndone", done_q.size(), 0);
    run(31, 80, 40, -1, 1'b0);
    idle(2);
    exp_frame(40, 1000);
    cmp("c4b");
    chk("c4_done_idx", first_done(), 73);
    done_q.delete();

    // 5: frame_start without in_valid is ignored
    drive(0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b1);
    idle(1);
    chk("c5_busy", bus.busy, 0);
    run(2, 20, -1, -1, 1'b0);
    idle(2);
    chk("c5_out", got_q.size(), 0);
    chk("c5_busy_end", bus.busy, 0);

    chk("lane_err", lane_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
